// File: rtl/pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// pipe_stage_skid
//
// One pipeline stage with a two-entry skid buffer.  The "main" entry drives the
// downstream outputs.  The "skid" entry catches the one word that upstream may
// still push in the cycle the stage turns non-ready.  Because of the skid
// entry, InReady can be a pure register of the stage state and never has a
// combinational path from OutReady.
//
// Parameters
//   CTRL_W  width of the control field (forced to zero when nothing is valid)
//   DATA_W  width of the data field
//   CNT_W   width of the saturating stall counter
//
// Ports
//   CLK        in   sole clock, rising edge
//   Reset      in   synchronous, active-high; clears state, data and counter
//   Flush      in   synchronous bubble insertion; drops every held entry
//   InValid    in   upstream presents an entry
//   InReady    out  stage can accept (registered, state-only)
//   InCtrl     in   control field of the incoming entry
//   InData     in   data field of the incoming entry
//   OutValid   out  stage presents an entry downstream
//   OutReady   in   downstream accepts this cycle
//   OutCtrl    out  control of the presented entry, zero when OutValid=0
//   OutData    out  data of the presented entry, holds last value otherwise
//   Occupancy  out  number of held entries (0, 1 or 2)
//   StallCount out  saturating count of cycles with OutValid=1, OutReady=0
// -----------------------------------------------------------------------------

// Property checker for the stage's externally visible invariants.
module pipe_stage_skid_chk #(
    parameter int CTRL_W = 9
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              InReady,
    input  logic              OutValid,
    input  logic [CTRL_W-1:0] OutCtrl,
    input  logic [1:0]        Occupancy
);

    // The state encoding 3 is unused and must never appear.
    a_occ_legal : assert property (@(posedge CLK) disable iff (Reset)
        Occupancy != 2'd3);

    // A bubble always carries an all-zero control field.
    a_ctrl_zero : assert property (@(posedge CLK) disable iff (Reset)
        OutValid || (OutCtrl == {CTRL_W{1'b0}}));

    // Ready only drops when both entries are occupied.
    a_ready_occ : assert property (@(posedge CLK) disable iff (Reset)
        InReady == (Occupancy != 2'd2));

    // Something is presented exactly when something is held.
    a_valid_occ : assert property (@(posedge CLK) disable iff (Reset)
        OutValid == (Occupancy != 2'd0));

endmodule

module pipe_stage_skid #(
    parameter int CTRL_W = 9,
    parameter int DATA_W = 96,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              Flush,
    input  logic              InValid,
    output logic              InReady,
    input  logic [CTRL_W-1:0] InCtrl,
    input  logic [DATA_W-1:0] InData,
    output logic              OutValid,
    input  logic              OutReady,
    output logic [CTRL_W-1:0] OutCtrl,
    output logic [DATA_W-1:0] OutData,
    output logic [1:0]        Occupancy,
    output logic [CNT_W-1:0]  StallCount
);

    // Encoding doubles as the occupancy value.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;

    logic [CTRL_W-1:0]   main_ctrl_r;
    logic [DATA_W-1:0]   main_data_r;
    logic [CTRL_W-1:0]   skid_ctrl_r;
    logic [DATA_W-1:0]   skid_data_r;
    logic [CTRL_W-1:0]   main_ctrl_nxt_s;
    logic [DATA_W-1:0]   main_data_nxt_s;
    logic [CTRL_W-1:0]   skid_ctrl_nxt_s;
    logic [DATA_W-1:0]   skid_data_nxt_s;

    // Output registers, loaded from the next-state view so that every
    // port is a flop output.
    logic                in_ready_r;
    logic                out_valid_r;
    logic [CTRL_W-1:0]   out_ctrl_r;
    logic [1:0]          occ_r;
    logic [CNT_W-1:0]    stall_cnt_r;

    logic                in_ready_nxt_s;
    logic                out_valid_nxt_s;
    logic [CTRL_W-1:0]   out_ctrl_nxt_s;
    logic [1:0]          occ_nxt_s;
    logic [CNT_W-1:0]    stall_cnt_nxt_s;

    logic                accept_s;
    logic                transfer_s;
    logic                stall_s;

    // Handshake qualifiers, taken from the registered port values.
    always_comb begin
        accept_s   = InValid & in_ready_r;
        transfer_s = out_valid_r & OutReady;
        stall_s    = out_valid_r & ~OutReady;
    end

    // Next-state and entry-steering logic of the skid buffer.
    always_comb begin
        state_nxt_s     = state_r;
        main_ctrl_nxt_s = main_ctrl_r;
        main_data_nxt_s = main_data_r;
        skid_ctrl_nxt_s = skid_ctrl_r;
        skid_data_nxt_s = skid_data_r;

        if (Flush) begin
            // Data registers are left untouched; the bubble is produced by
            // dropping the state to EMPTY, which zeroes OutCtrl via OutValid.
            state_nxt_s = ST_EMPTY;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s) begin
                        state_nxt_s     = ST_ONE;
                        main_ctrl_nxt_s = InCtrl;
                        main_data_nxt_s = InData;
                    end else begin
                        state_nxt_s = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (accept_s && transfer_s) begin
                        // Pass-through: the new entry replaces the leaving one.
                        state_nxt_s     = ST_ONE;
                        main_ctrl_nxt_s = InCtrl;
                        main_data_nxt_s = InData;
                    end else if (accept_s) begin
                        // Downstream stalled: park the new entry behind main.
                        state_nxt_s     = ST_FULL;
                        skid_ctrl_nxt_s = InCtrl;
                        skid_data_nxt_s = InData;
                    end else if (transfer_s) begin
                        state_nxt_s = ST_EMPTY;
                    end else begin
                        state_nxt_s = ST_ONE;
                    end
                end
                ST_FULL: begin
                    // InReady is low here, so upstream is never accepted.
                    if (transfer_s) begin
                        state_nxt_s     = ST_ONE;
                        main_ctrl_nxt_s = skid_ctrl_r;
                        main_data_nxt_s = skid_data_r;
                    end else begin
                        state_nxt_s = ST_FULL;
                    end
                end
                default: begin
                    state_nxt_s = ST_EMPTY;
                end
            endcase
        end
    end

    // Derive the next values of the registered status outputs.
    always_comb begin
        in_ready_nxt_s  = 1'b1;
        out_valid_nxt_s = 1'b0;
        out_ctrl_nxt_s  = {CTRL_W{1'b0}};
        occ_nxt_s       = 2'd0;

        case (state_nxt_s)
            ST_EMPTY: begin
                in_ready_nxt_s  = 1'b1;
                out_valid_nxt_s = 1'b0;
                occ_nxt_s       = 2'd0;
            end
            ST_ONE: begin
                in_ready_nxt_s  = 1'b1;
                out_valid_nxt_s = 1'b1;
                occ_nxt_s       = 2'd1;
            end
            ST_FULL: begin
                in_ready_nxt_s  = 1'b0;
                out_valid_nxt_s = 1'b1;
                occ_nxt_s       = 2'd2;
            end
            default: begin
                in_ready_nxt_s  = 1'b1;
                out_valid_nxt_s = 1'b0;
                occ_nxt_s       = 2'd0;
            end
        endcase

        if (out_valid_nxt_s) begin
            out_ctrl_nxt_s = main_ctrl_nxt_s;
        end else begin
            out_ctrl_nxt_s = {CTRL_W{1'b0}};
        end
    end

    // Saturating stall counter; Flush deliberately has no effect on it.
    always_comb begin
        stall_cnt_nxt_s = stall_cnt_r;
        if (stall_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_nxt_s = stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_nxt_s = stall_cnt_r;
        end
    end

    // State, entry storage and output registers.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_r     <= ST_EMPTY;
            main_ctrl_r <= {CTRL_W{1'b0}};
            main_data_r <= {DATA_W{1'b0}};
            skid_ctrl_r <= {CTRL_W{1'b0}};
            skid_data_r <= {DATA_W{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_ctrl_r  <= {CTRL_W{1'b0}};
            occ_r       <= 2'd0;
            stall_cnt_r <= {CNT_W{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            main_ctrl_r <= main_ctrl_nxt_s;
            main_data_r <= main_data_nxt_s;
            skid_ctrl_r <= skid_ctrl_nxt_s;
            skid_data_r <= skid_data_nxt_s;
            in_ready_r  <= in_ready_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            out_ctrl_r  <= out_ctrl_nxt_s;
            occ_r       <= occ_nxt_s;
            stall_cnt_r <= stall_cnt_nxt_s;
        end
    end

    assign InReady    = in_ready_r;
    assign OutValid   = out_valid_r;
    assign OutCtrl    = out_ctrl_r;
    assign OutData    = main_data_r;
    assign Occupancy  = occ_r;
    assign StallCount = stall_cnt_r;

    pipe_stage_skid_chk #(
        .CTRL_W (CTRL_W)
    ) u_chk (
        .CLK       (CLK),
        .Reset     (Reset),
        .InReady   (in_ready_r),
        .OutValid  (out_valid_r),
        .OutCtrl   (out_ctrl_r),
        .Occupancy (occ_r)
    );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// Bench for pipe_stage_skid.  Two instances share every input: one with the
// default 16-bit stall counter and one with CNT_W=4 so saturation is reachable.
// A queue-based model (at most two entries, FIFO order) predicts all outputs.
// -----------------------------------------------------------------------------
module tb_pipe_stage_skid;

    logic        CLK = 1'b0;
    logic        Reset, Flush, InValid, OutReady;
    logic [8:0]  InCtrl;
    logic [95:0] InData;

    logic        a_rdy, a_vld, b_rdy, b_vld;
    logic [8:0]  a_ctrl, b_ctrl;
    logic [95:0] a_data, b_data;
    logic [1:0]  a_occ, b_occ;
    logic [15:0] a_stall;
    logic [3:0]  b_stall;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    pipe_stage_skid dut_a (
        .CLK(CLK), .Reset(Reset), .Flush(Flush), .InValid(InValid), .InReady(a_rdy),
        .InCtrl(InCtrl), .InData(InData), .OutValid(a_vld), .OutReady(OutReady),
        .OutCtrl(a_ctrl), .OutData(a_data), .Occupancy(a_occ), .StallCount(a_stall)
    );

    pipe_stage_skid #(.CNT_W(4)) dut_b (
        .CLK(CLK), .Reset(Reset), .Flush(Flush), .InValid(InValid), .InReady(b_rdy),
        .InCtrl(InCtrl), .InData(InData), .OutValid(b_vld), .OutReady(OutReady),
        .OutCtrl(b_ctrl), .OutData(b_data), .Occupancy(b_occ), .StallCount(b_stall)
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic [8:0]  ctrl;
        logic [95:0] data;
    } entry_t;

    entry_t      mq[$];
    logic [95:0] m_held  = 96'd0;
    int          m_stall16 = 0;
    int          m_stall4  = 0;

    task automatic model_edge();
        bit acc, xfer;
        entry_t e;
        if (Reset) begin
            mq.delete();
            m_held    = 96'd0;
            m_stall16 = 0;
            m_stall4  = 0;
        end else begin
            acc  = InValid && (mq.size() < 2);
            xfer = (mq.size() > 0) && OutReady;
            if ((mq.size() > 0) && !OutReady) begin
                if (m_stall16 < 65535) m_stall16++;
                if (m_stall4 < 15) m_stall4++;
            end
            if (xfer) void'(mq.pop_front());
            if (Flush) mq.delete();
            else if (acc) begin
                e.ctrl = InCtrl;
                e.data = InData;
                mq.push_back(e);
            end
            if (mq.size() > 0) m_held = mq[0].data;
        end
    endtask

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        logic        e_vld;
        logic [8:0]  e_ctrl;
        e_vld  = mq.size() > 0;
        e_ctrl = e_vld ? mq[0].ctrl : 9'd0;
        chk({tag, "_a_rdy"},   96'(a_rdy),   96'(mq.size() < 2));
        chk({tag, "_a_vld"},   96'(a_vld),   96'(e_vld));
        chk({tag, "_a_ctrl"},  96'(a_ctrl),  96'(e_ctrl));
        chk({tag, "_a_data"},  a_data,       m_held);
        chk({tag, "_a_occ"},   96'(a_occ),   96'(mq.size()));
        chk({tag, "_a_stall"}, 96'(a_stall), 96'(m_stall16));
        chk({tag, "_b_vld"},   96'(b_vld),   96'(e_vld));
        chk({tag, "_b_ctrl"},  96'(b_ctrl),  96'(e_ctrl));
        chk({tag, "_b_data"},  b_data,       m_held);
        chk({tag, "_b_occ"},   96'(b_occ),   96'(mq.size()));
        chk({tag, "_b_rdy"},   96'(b_rdy),   96'(mq.size() < 2));
        chk({tag, "_b_stall"}, 96'(b_stall), 96'(m_stall4));
    endtask

    // Drive one cycle of inputs, let the edge happen, sample 1 ns later.
    task automatic step(input logic r, input logic f, input logic v,
                        input logic [8:0] c, input logic [95:0] d, input logic o,
                        input string tag);
        Reset = r; Flush = f; InValid = v; InCtrl = c; InData = d; OutReady = o;
        @(posedge CLK);
        model_edge();
        #1;
        check_model(tag);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        rst, fl, vld;
        logic [8:0]  ctrl;
        logic [95:0] data;
        logic        ordy;
        logic        e_rdy, e_vld;
        logic [8:0]  e_ctrl;
        logic [95:0] e_data;
        logic [1:0]  e_occ;
        logic [15:0] e_stall;
    } vec_t;

    vec_t vecs[21];

    initial begin
        Reset = 1'b1; Flush = 1'b0; InValid = 1'b0; InCtrl = 9'd0; InData = 96'd0; OutReady = 1'b0;

        //             rst   fl    vld   ctrl     data    ordy  rdy   vld   ectrl    edata   occ   stall
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 9'h000, 96'h0, 1'b0, 1'b1, 1'b0, 9'h000, 96'h0, 2'd0, 16'd0};
        // single entry, one-cycle latency then bubble
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 9'h1A5, 96'hA, 1'b1, 1'b1, 1'b1, 9'h1A5, 96'hA, 2'd1, 16'd0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 9'h000, 96'h0, 1'b1, 1'b1, 1'b0, 9'h000, 96'hA, 2'd0, 16'd0};
        // back-to-back stream 1..4
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 9'h001, 96'h1, 1'b1, 1'b1, 1'b1, 9'h001, 96'h1, 2'd1, 16'd0};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 9'h002, 96'h2, 1'b1, 1'b1, 1'b1, 9'h002, 96'h2, 2'd1, 16'd0};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 9'h003, 96'h3, 1'b1, 1'b1, 1'b1, 9'h003, 96'h3, 2'd1, 16'd0};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 9'h004, 96'h4, 1'b1, 1'b1, 1'b1, 9'h004, 96'h4, 2'd1, 16'd0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 9'h000, 96'h0, 1'b1, 1'b1, 1'b0, 9'h000, 96'h4, 2'd0, 16'd0};
        // stalled stream 1,2,3 then release
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 9'h001, 96'h1, 1'b0, 1'b1, 1'b1, 9'h001, 96'h1, 2'd1, 16'd0};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 9'h002, 96'h2, 1'b0, 1'b0, 1'b1, 9'h001, 96'h1, 2'd2, 16'd1};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 9'h003, 96'h3, 1'b0, 1'b0, 1'b1, 9'h001, 96'h1, 2'd2, 16'd2};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 9'h003, 96'h3, 1'b1, 1'b1, 1'b1, 9'h002, 96'h2, 2'd1, 16'd2};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 9'h003, 96'h3, 1'b1, 1'b1, 1'b1, 9'h003, 96'h3, 2'd1, 16'd2};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 9'h000, 96'h0, 1'b1, 1'b1, 1'b0, 9'h000, 96'h3, 2'd0, 16'd2};
        // fill with 5,6 then flush while 7 is offered
        vecs[14] = '{1'b0, 1'b0, 1'b1, 9'h005, 96'h5, 1'b0, 1'b1, 1'b1, 9'h005, 96'h5, 2'd1, 16'd2};
        vecs[15] = '{1'b0, 1'b0, 1'b1, 9'h006, 96'h6, 1'b0, 1'b0, 1'b1, 9'h005, 96'h5, 2'd2, 16'd3};
        vecs[16] = '{1'b0, 1'b1, 1'b1, 9'h007, 96'h7, 1'b1, 1'b1, 1'b0, 9'h000, 96'h5, 2'd0, 16'd3};
        vecs[17] = '{1'b0, 1'b0, 1'b0, 9'h000, 96'h0, 1'b1, 1'b1, 1'b0, 9'h000, 96'h5, 2'd0, 16'd3};
        // fill with 8,9 then reset together with flush
        vecs[18] = '{1'b0, 1'b0, 1'b1, 9'h008, 96'h8, 1'b0, 1'b1, 1'b1, 9'h008, 96'h8, 2'd1, 16'd3};
        vecs[19] = '{1'b0, 1'b0, 1'b1, 9'h009, 96'h9, 1'b0, 1'b0, 1'b1, 9'h008, 96'h8, 2'd2, 16'd4};
        vecs[20] = '{1'b1, 1'b1, 1'b1, 9'h00A, 96'hA, 1'b0, 1'b1, 1'b0, 9'h000, 96'h0, 2'd0, 16'd0};

        for (int i = 0; i < 21; i++) begin
            step(vecs[i].rst, vecs[i].fl, vecs[i].vld, vecs[i].ctrl, vecs[i].data,
                 vecs[i].ordy, $sformatf("vec%0d_model", i));
            chk($sformatf("vec%0d_rdy", i),   96'(a_rdy),   96'(vecs[i].e_rdy));
            chk($sformatf("vec%0d_vld", i),   96'(a_vld),   96'(vecs[i].e_vld));
            chk($sformatf("vec%0d_ctrl", i),  96'(a_ctrl),  96'(vecs[i].e_ctrl));
            chk($sformatf("vec%0d_data", i),  a_data,       vecs[i].e_data);
            chk($sformatf("vec%0d_occ", i),   96'(a_occ),   96'(vecs[i].e_occ));
            chk($sformatf("vec%0d_stall", i), 96'(a_stall), 96'(vecs[i].e_stall));
            chk($sformatf("vec%0d_stall4", i), 96'(b_stall), 96'(vecs[i].e_stall));
        end

        // ---------------- saturation sequence ----------------
        step(1'b1, 1'b0, 1'b0, 9'h000, 96'h0,  1'b0, "sat_rst");
        step(1'b0, 1'b0, 1'b1, 9'h0C3, 96'hC3, 1'b0, "sat_acc");
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, 1'b0, 9'h000, 96'h0, 1'b0, $sformatf("sat%0d", i));
        end
        chk("sat_stall4_15",  96'(b_stall), 96'd15);
        chk("sat_stall16_20", 96'(a_stall), 96'd20);
        chk("sat_held_ctrl",  96'(b_ctrl),  96'h0C3);
        step(1'b0, 1'b0, 1'b0, 9'h000, 96'h0, 1'b1, "sat_drain");
        chk("sat_stall4_stay", 96'(b_stall), 96'd15);
        chk("sat_drain_vld",   96'(b_vld),   96'd0);

        // ---------------- randomized phase ----------------
        begin
            int thr;
            thr = 60;
            for (int i = 0; i < 3000; i++) begin
                if ((i % 32) == 0) begin
                    case ($urandom_range(0, 2))
                        0:       thr = 10;
                        1:       thr = 60;
                        default: thr = 100;
                    endcase
                end
                step($urandom_range(0, 149) == 0,
                     $urandom_range(0, 19) == 0,
                     $urandom_range(0, 99) < 70,
                     9'($urandom),
                     {$urandom, $urandom, $urandom},
                     $urandom_range(0, 99) < thr,
                     $sformatf("rnd%0d", i));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 Parameter: CTRL_W, default 9, width of control field; control bits are forced to 0 whenever no valid entry is presented.
REQ-002 Parameter: DATA_W, default 96, width of data field (operands, immediate, register indices).
REQ-003 Parameter: CNT_W, default 16, width of stall counter.
REQ-004 Port: CLK  in  1  sole clock; all state updates on rising edge.
REQ-005 Port: Reset  in  1  synchronous, active-high reset.
REQ-006 Port: Flush  in  1  synchronous bubble insertion; discards all held entries.
REQ-007 Port: InValid  in  1  upstream presents an entry.
REQ-008 Port: InReady  out  1  stage can accept; registered (depends only on state, not on OutReady).
REQ-009 Port: InCtrl  in  CTRL_W  control field of incoming entry.
REQ-010 Port: InData  in  DATA_W  data field of incoming entry.
REQ-011 Port: OutValid  out  1  stage presents an entry downstream.
REQ-012 Port: OutReady  in  1  downstream accepts this cycle.
REQ-013 Port: OutCtrl  out  CTRL_W  control of presented entry; all zeros when OutValid=0.
REQ-014 Port: OutData  out  DATA_W  data of presented entry; holds last value when OutValid=0.
REQ-015 Port: Occupancy  out  2  entries held: 0, 1 or 2.
REQ-016 Port: StallCount  out  CNT_W  cycles with OutValid=1 and OutReady=0, saturating.

Function
REQ-017 Accept when InValid=1 and InReady=1; transfer out when OutValid=1 and OutReady=1.
REQ-018 Storage: main entry (drives outputs) and skid entry; states EMPTY (0), ONE (1), FULL (2).
REQ-019 InReady=1 in EMPTY and ONE; 0 in FULL. OutValid=1 in ONE and FULL.
REQ-020 EMPTY: accept -> ONE, main<=input; else stay.
REQ-021 ONE: accept and transfer -> ONE, main<=input; accept without transfer -> FULL, skid<=input; transfer without accept -> EMPTY; neither -> hold.
REQ-022 FULL: transfer -> ONE, main<=skid; else hold; InValid ignored.
REQ-023 Latency: entry accepted in cycle N appears on OutData/OutCtrl with OutValid=1 in cycle N+1 when state was EMPTY or transferring ONE.
REQ-024 Throughput: one entry per cycle sustained while OutReady=1; no bubbles inserted by the stage.
REQ-025 Ordering: entries leave in acceptance order; none dropped or duplicated except by Flush/Reset.
REQ-026 Flush=1: next state EMPTY regardless of handshakes; entry offered in the same cycle is discarded; a transfer out in that cycle still counts as delivered downstream.
REQ-027 Flush does not alter data registers; OutCtrl becomes 0 via OutValid=0.
REQ-028 StallCount increments by 1 each cycle OutValid=1 and OutReady=0, saturates at 2^CNT_W-1, cleared only by Reset; Flush does not clear it.
REQ-029 Occupancy equals state encoding (EMPTY=0, ONE=1, FULL=2); value 3 never produced.

Reset
REQ-030 Reset=1 at a rising edge: state EMPTY, main and skid control/data cleared to 0, StallCount 0; Reset overrides Flush and all handshakes.
REQ-031 During and after the reset cycle: InReady=1, OutValid=0, OutCtrl=0, OutData=0, Occupancy=0 until an entry is accepted.
REQ-032 Reset mid-operation (ONE or FULL) discards all entries; no partial output.

Verification
REQ-033 Reset, then InValid=1, InCtrl=9'h1A5, InData=96'hA for 1 cycle, OutReady=1 -> next cycle OutValid=1, OutCtrl=9'h1A5, OutData=96'hA; following cycle OutValid=0, OutCtrl=0.
REQ-034 Stream 1,2,3,4 back-to-back with OutReady=1 -> outputs 1,2,3,4 on consecutive cycles, InReady constantly 1, StallCount=0.
REQ-035 Stream 1,2,3 with OutReady=0 from cycle of first accept -> Occupancy 1 then 2, InReady=0, entry 3 held upstream; OutReady=1 afterwards -> 1,2,3 delivered in order, StallCount equals stalled cycles.
REQ-036 FULL with entries 5,6, assert Flush with InValid=1 data 7 -> next cycle Occupancy=0, OutValid=0, OutCtrl=0; 7 never appears; StallCount unchanged.
REQ-037 CNT_W=4, OutReady=0 for 20 cycles with one entry held -> StallCount reaches 15 and stays 15.
REQ-038 Reset asserted while FULL and Flush=1 -> next cycle all outputs zero, InReady=1, StallCount=0.
